// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: valid/ready byte input, LSB-first frames on txd,
// one bit per synchronised rising edge of the baud clock clkbps.
module uart_tx_fifo #(
  parameter int DEPTH    = 4,
  parameter int DATAW    = 8,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clkbps,
  input  logic [DATAW-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       txd,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (DATAW > 1) ? $clog2(DATAW) : 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATAW - 1);
  localparam logic          LAST_STOP = (STOPBITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  function automatic logic parity_f(input logic [DATAW-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 2) begin
      parity_f = ~p;
    end else begin
      parity_f = p;
    end
  endfunction

  logic             bps_meta_r, bps_sync_r, bps_prev_r;
  logic             bit_tick_s;
  logic [DATAW-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             push_s, load_s;
  logic             ready_r, busy_r;
  state_t           state_r, state_nxt_s;
  logic [DATAW-1:0] shreg_r, shreg_nxt_s;
  logic [BW-1:0]    bitcnt_r, bitcnt_nxt_s;
  logic             stopcnt_r, stopcnt_nxt_s;
  logic             par_r, par_nxt_s;
  logic             txd_r, txd_nxt_s;

  assign bit_tick_s = bps_sync_r & ~bps_prev_r;
  assign push_s     = tx_valid & ready_r;
  assign tx_ready   = ready_r;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;

  // baud clock synchroniser and edge history
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bps_meta_r <= 1'b0;
      bps_sync_r <= 1'b0;
      bps_prev_r <= 1'b0;
    end else begin
      bps_meta_r <= clkbps;
      bps_sync_r <= bps_meta_r;
      bps_prev_r <= bps_sync_r;
    end
  end

  // FIFO storage; reset clears it so an aborted frame leaves nothing behind
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s) begin
      mem_r[wptr_r] <= tx_data;
    end
  end

  // occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, load_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, count and the status outputs derived from the next count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= CNT_ZERO;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_ONE;
      if (load_s) rptr_r <= rptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != CNT_FULL);
      busy_r  <= (state_nxt_s != IDLE) | (count_nxt_s != CNT_ZERO);
    end
  end

  // frame sequencer: all movement happens on bit_tick only
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    bitcnt_nxt_s  = bitcnt_r;
    stopcnt_nxt_s = stopcnt_r;
    par_nxt_s     = par_r;
    txd_nxt_s     = txd_r;
    load_s        = 1'b0;
    if (bit_tick_s) begin
      case (state_r)
        IDLE: begin
          if (count_r != CNT_ZERO) begin
            load_s      = 1'b1;
            shreg_nxt_s = mem_r[rptr_r];
            par_nxt_s   = parity_f(mem_r[rptr_r]);
            txd_nxt_s   = 1'b0;
            state_nxt_s = START;
          end else begin
            txd_nxt_s   = 1'b1;
          end
        end
        START: begin
          txd_nxt_s    = shreg_r[0];
          shreg_nxt_s  = {1'b0, shreg_r[DATAW-1:1]};
          bitcnt_nxt_s = BIT_ZERO;
          state_nxt_s  = DATA;
        end
        DATA: begin
          if (bitcnt_r != LAST_BIT) begin
            txd_nxt_s    = shreg_r[0];
            shreg_nxt_s  = {1'b0, shreg_r[DATAW-1:1]};
            bitcnt_nxt_s = bitcnt_r + BIT_ONE;
          end else if (PARITY != 0) begin
            txd_nxt_s    = par_r;
            state_nxt_s  = PAR;
          end else begin
            txd_nxt_s     = 1'b1;
            stopcnt_nxt_s = 1'b0;
            state_nxt_s   = STOP;
          end
        end
        PAR: begin
          txd_nxt_s     = 1'b1;
          stopcnt_nxt_s = 1'b0;
          state_nxt_s   = STOP;
        end
        STOP: begin
          if (stopcnt_r != LAST_STOP) begin
            stopcnt_nxt_s = stopcnt_r + 1'b1;
            txd_nxt_s     = 1'b1;
          end else if (count_r != CNT_ZERO) begin
            // next frame starts straight after the last stop bit
            load_s      = 1'b1;
            shreg_nxt_s = mem_r[rptr_r];
            par_nxt_s   = parity_f(mem_r[rptr_r]);
            txd_nxt_s   = 1'b0;
            state_nxt_s = START;
          end else begin
            txd_nxt_s   = 1'b1;
            state_nxt_s = IDLE;
          end
        end
        default: begin
          txd_nxt_s   = 1'b1;
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // sequencer state and registered line output
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      bitcnt_r  <= BIT_ZERO;
      stopcnt_r <= 1'b0;
      par_r     <= 1'b0;
      txd_r     <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      shreg_r   <= shreg_nxt_s;
      bitcnt_r  <= bitcnt_nxt_s;
      stopcnt_r <= stopcnt_nxt_s;
      par_r     <= par_nxt_s;
      txd_r     <= txd_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (no parity/1 stop, even/2 stop, odd/1 stop)
// checked against a byte scoreboard and bench-computed frame timing.
module tb_uart_tx_fifo;

  logic            clk, nrst, clkbps, bps_en;
  logic [2:0][7:0] din;
  logic [2:0]      vin, rdy, txdw, bsy;
  logic [2:0]      cnt0, cnt1, cnt2;
  int              cyc = 0;
  int              n_assert = 0;
  int              n_fail = 0;
  logic [7:0]      sb0[$], sb1[$], sb2[$];

  uart_tx_fifo u_main (.clk(clk), .nrst(nrst), .clkbps(clkbps), .tx_data(din[0]), .tx_valid(vin[0]),
    .tx_ready(rdy[0]), .txd(txdw[0]), .busy(bsy[0]), .fifo_count(cnt0));
  uart_tx_fifo #(.PARITY(1), .STOPBITS(2)) u_even (.clk(clk), .nrst(nrst), .clkbps(clkbps),
    .tx_data(din[1]), .tx_valid(vin[1]), .tx_ready(rdy[1]), .txd(txdw[1]), .busy(bsy[1]), .fifo_count(cnt1));
  uart_tx_fifo #(.PARITY(2), .STOPBITS(1)) u_odd (.clk(clk), .nrst(nrst), .clkbps(clkbps),
    .tx_data(din[2]), .tx_valid(vin[2]), .tx_ready(rdy[2]), .txd(txdw[2]), .busy(bsy[2]), .fifo_count(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16-clk baud clock; edges offset from clk edges; forced low while disabled
  initial begin
    clkbps = 1'b0;
    #2;
    forever #80 clkbps = bps_en ? ~clkbps : 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [7:0] d);
    case (k)
      0:       sb0.push_back(d);
      1:       sb1.push_back(d);
      default: sb2.push_back(d);
    endcase
  endtask

  task automatic sb_pop(input int k, output logic [7:0] d, output logic ok);
    d = 8'h00;
    ok = 1'b0;
    case (k)
      0:       if (sb0.size() != 0) begin d = sb0.pop_front(); ok = 1'b1; end
      1:       if (sb1.size() != 0) begin d = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() != 0) begin d = sb2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // called at a negedge; holds valid until the DUT's ready is seen before a rising edge
  task automatic push(input int k, input logic [7:0] d, input int budget);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    din[k] = d;
    vin[k] = 1'b1;
    while (!ok && n < budget) begin
      if (rdy[k]) ok = 1'b1;
      @(negedge clk);
      n++;
    end
    vin[k] = 1'b0;
    if (ok) sb_push(k, d);
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_low(input int k, input int budget, output logic found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      if (txdw[k] == 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  // receive one frame by mid-bit sampling; returns at mid of last stop bit
  task automatic rx(input int k, input int pmode, input int nst, output int tstart);
    logic       found, ok;
    logic [7:0] d, e;
    tstart = 0;
    wait_low(k, 800, found);
    chk("rx_start_seen", 32'(found), 32'd1);
    if (found) begin
      tstart = cyc;
      repeat (8) @(negedge clk);
      chk("rx_start_bit", 32'(txdw[k]), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        d[i] = txdw[k];
      end
      sb_pop(k, e, ok);
      chk("rx_sb_nonempty", 32'(ok), 32'd1);
      chk("rx_data", 32'(d), 32'(e));
      if (pmode != 0) begin
        repeat (16) @(negedge clk);
        chk("rx_parity", 32'(txdw[k]), (pmode == 1) ? 32'(^e) : 32'(~^e));
      end
      for (int s = 0; s < nst; s++) begin
        repeat (16) @(negedge clk);
        chk("rx_stop", 32'(txdw[k]), 32'd1);
      end
    end
  endtask

  logic       found;
  logic [7:0] e;
  logic       ok;
  logic [9:0] pat;
  int         t1, t2, t3;

  initial begin
    nrst = 1'b0;
    vin = 3'b000;
    din = '0;
    bps_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txdw[0]), 32'd1);
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_count", 32'(cnt0), 32'd0);
    chk("reset_ready", 32'(rdy[0]), 32'd1);
    nrst = 1'b1;
    repeat (20) @(negedge clk);

    // single byte, level-exact frame shape
    push(0, 8'hA5, 50);
    wait_low(0, 100, found);
    chk("single_start_seen", 32'(found), 32'd1);
    sb_pop(0, e, ok);
    chk("single_sb", 32'(ok), 32'd1);
    pat = {1'b1, e, 1'b0};
    for (int b = 0; b < 10; b++) begin
      chk("single_bit_early", 32'(txdw[0]), 32'(pat[b]));
      repeat (15) @(negedge clk);
      chk("single_bit_late", 32'(txdw[0]), 32'(pat[b]));
      @(negedge clk);
    end
    chk("single_busy_drop", 32'(bsy[0]), 32'd0);
    chk("single_idle_txd", 32'(txdw[0]), 32'd1);

    // back-to-back frames, 20 bit periods total
    repeat (20) @(negedge clk);
    push(0, 8'h00, 50);
    push(0, 8'hFF, 50);
    rx(0, 0, 1, t1);
    rx(0, 0, 1, t2);
    chk("b2b_start_gap", 32'(t2 - t1), 32'd160);
    while (cyc < t1 + 319) @(negedge clk);
    chk("b2b_busy_last", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    chk("b2b_busy_end", 32'(bsy[0]), 32'd0);

    // reset mid-frame while txd is low
    repeat (20) @(negedge clk);
    push(0, 8'h81, 50);
    push(0, 8'h42, 50);
    wait_low(0, 100, found);
    chk("rst_start_seen", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(txdw[0]), 32'd1);
    chk("rst_mid_busy", 32'(bsy[0]), 32'd0);
    chk("rst_mid_count", 32'(cnt0), 32'd0);
    chk("rst_mid_ready", 32'(rdy[0]), 32'd1);
    sb0.delete();
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    push(0, 8'h3C, 50);
    rx(0, 0, 1, t1);
    repeat (16) @(negedge clk);
    chk("rst_after_count", 32'(cnt0), 32'd0);

    // fill with baud clock stopped; fifth push waits for the first pop
    bps_en = 1'b0;
    repeat (12) @(negedge clk);
    push(0, 8'h11, 5);
    push(0, 8'h22, 5);
    push(0, 8'h33, 5);
    push(0, 8'h44, 5);
    chk("fill_count", 32'(cnt0), 32'd4);
    chk("fill_ready", 32'(rdy[0]), 32'd0);
    fork
      begin
        push(0, 8'h55, 300);
        chk("fill_5th_count", 32'(cnt0), 32'd4);
      end
      begin
        repeat (20) @(negedge clk);
        chk("fill_held_count", 32'(cnt0), 32'd4);
        chk("fill_held_txd", 32'(txdw[0]), 32'd1);
        bps_en = 1'b1;
        for (int i = 0; i < 5; i++) rx(0, 0, 1, t3);
      end
    join

    // push coinciding with the load tick at count 1
    repeat (16) @(negedge clk);
    chk("simul_idle", 32'(bsy[0]), 32'd0);
    bps_en = 1'b0;
    repeat (12) @(negedge clk);
    push(0, 8'h5A, 5);
    repeat (5) @(negedge clk);
    chk("simul_pre_count", 32'(cnt0), 32'd1);
    bps_en = 1'b1;
    @(posedge clkbps);
    @(negedge clk);
    @(negedge clk);
    push(0, 8'hC3, 2);
    chk("simul_count", 32'(cnt0), 32'd1);
    rx(0, 0, 1, t1);
    rx(0, 0, 1, t2);
    chk("simul_gap", 32'(t2 - t1), 32'd160);

    // parity variants and two stop bits
    repeat (16) @(negedge clk);
    bps_en = 1'b0;
    repeat (12) @(negedge clk);
    push(1, 8'h07, 5);
    push(1, 8'h07, 5);
    push(2, 8'h07, 5);
    bps_en = 1'b1;
    fork
      begin
        rx(1, 1, 2, t1);
        rx(1, 1, 2, t2);
        chk("two_stop_gap", 32'(t2 - t1), 32'd192);
      end
      begin
        rx(2, 2, 1, t3);
      end
    join
    repeat (20) @(negedge clk);
    chk("par_even_idle", 32'(bsy[1]), 32'd0);
    chk("par_odd_idle", 32'(bsy[2]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
